// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard bundle: hazard inputs from ID/EX/MEM, stall/flush controls back to the pipeline.
interface hazard_stall_unit_if #(parameter int CNT_W = 32);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_uses_rs1_i;
    logic             id_uses_rs2_i;
    logic [4:0]       ex_rd_i;
    logic             ex_memread_i;
    logic             mem_req_i;
    logic             mem_ready_i;
    logic             branch_taken_i;
    logic             Hazard_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_write_o;
    logic             exmem_write_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [1:0]       state_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ex_rd_i, ex_memread_i,
               mem_req_i, mem_ready_i, branch_taken_i,
        input  Hazard_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
               exmem_write_o, stall_cnt_o, state_o
    );
    modport slave (
        input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ex_rd_i, ex_memread_i,
               mem_req_i, mem_ready_i, branch_taken_i,
        output Hazard_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
               exmem_write_o, stall_cnt_o, state_o
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use bubbles, memory-wait freeze, branch flush, stall counter.
module hazard_stall_unit #(
    parameter int LU_STALL_CYC = 1,
    parameter int CNT_W        = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

    state_t           state, stateNxt;
    logic [2:0]       luRem, luRemNxt;
    logic             resumeLu, resumeNxt;
    logic [CNT_W-1:0] stallCnt;
    logic             lu, mw, stallOut;

    assign lu = hz.ex_memread_i && (hz.ex_rd_i != 5'd0) &&
                ((hz.id_uses_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                 (hz.id_uses_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));
    assign mw = hz.mem_req_i && !hz.mem_ready_i;

    // Bubble sequencing is active in LU_STALL, and on the release cycle of a wait that interrupted it.
    assign stallOut = !mw && ((state == LU_STALL) || (state == MEM_WAIT && resumeLu));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= RUN;
            luRem    <= 3'd0;
            resumeLu <= 1'b0;
        end else begin
            state    <= stateNxt;
            luRem    <= luRemNxt;
            resumeLu <= resumeNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        luRemNxt  = luRem;
        resumeNxt = resumeLu;
        if (mw) begin
            if (state != MEM_WAIT) begin
                stateNxt  = MEM_WAIT;
                resumeNxt = (state == LU_STALL);
            end
        end else if (stallOut) begin
            luRemNxt = luRem - 3'd1;
            stateNxt = (luRem == 3'd1) ? RUN : LU_STALL;
        end else begin
            // A taken branch squashes the ID instruction, so its load-use hit is moot.
            stateNxt = RUN;
            if (!hz.branch_taken_i && lu && (LU_STALL_CYC > 1)) begin
                stateNxt = LU_STALL;
                luRemNxt = 3'(LU_STALL_CYC - 1);
            end
        end
    end

    always_comb begin
        hz.Hazard_o      = 1'b0;
        hz.ifid_flush_o  = 1'b0;
        hz.pc_write_o    = 1'b1;
        hz.ifid_write_o  = 1'b1;
        hz.idex_write_o  = 1'b1;
        hz.exmem_write_o = 1'b1;
        if (!sys_rst_n) begin
            hz.Hazard_o = 1'b0;
        end else if (mw) begin
            hz.pc_write_o    = 1'b0;
            hz.ifid_write_o  = 1'b0;
            hz.idex_write_o  = 1'b0;
            hz.exmem_write_o = 1'b0;
        end else if (stallOut) begin
            hz.Hazard_o     = 1'b1;
            hz.pc_write_o   = 1'b0;
            hz.ifid_write_o = 1'b0;
        end else if (hz.branch_taken_i) begin
            hz.Hazard_o     = 1'b1;
            hz.ifid_flush_o = 1'b1;
        end else if (lu) begin
            hz.Hazard_o     = 1'b1;
            hz.pc_write_o   = 1'b0;
            hz.ifid_write_o = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            stallCnt <= '0;
        else if (!hz.pc_write_o && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + 1'b1;
    end

    assign hz.stall_cnt_o = stallCnt;
    assign hz.state_o     = state;
endmodule
